// File: rtl/wwm_turn_sm_if.sv
// Signal bundle between the turn sequencer and the game front end.
// Start, Ack and Fire are level strobes with no ready: each is acted on only in its own state.
interface wwm_turn_sm_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int COORD_W     = 10,
   parameter int SCORE_W     = 4
);
   localparam int PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1;

   logic                         Start;
   logic                         Ack;
   logic                         Fire;
   logic [COORD_W-1:0]           projectileCenterX;
   logic [COORD_W-1:0]           projectileCenterY;
   logic [COORD_W-1:0]           tgtXLo;
   logic [COORD_W-1:0]           tgtXHi;
   logic [COORD_W-1:0]           tgtYLo;
   logic [COORD_W-1:0]           tgtYHi;
   logic                         q_I;
   logic                         q_Shoot;
   logic                         q_Animate;
   logic                         q_Score;
   logic                         q_Done;
   logic [PW-1:0]                curPlayer;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores;
   logic [PW-1:0]                winner;
   logic                         hitPulse;
   logic                         missPulse;

   modport master (
      output Start, Ack, Fire, projectileCenterX, projectileCenterY,
             tgtXLo, tgtXHi, tgtYLo, tgtYHi,
      input  q_I, q_Shoot, q_Animate, q_Score, q_Done, curPlayer, scores,
             winner, hitPulse, missPulse
   );

   modport slave (
      input  Start, Ack, Fire, projectileCenterX, projectileCenterY,
             tgtXLo, tgtXHi, tgtYLo, tgtYHi,
      output q_I, q_Shoot, q_Animate, q_Score, q_Done, curPlayer, scores,
             winner, hitPulse, missPulse
   );
endinterface

// File: rtl/wwm_turn_sm.sv
// Turn sequencer for a multi-player artillery game: whose turn, shot outcome, scoring, match end.
// Every output is a register; the one-hot state is visible directly on q_*.
module wwm_turn_sm #(
   parameter int NUM_PLAYERS = 2,
   parameter int COORD_W     = 10,
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 3,
   parameter int ARENA_XMIN  = 160,
   parameter int ARENA_XMAX  = 775,
   parameter int ARENA_YMIN  = 50,
   parameter int ARENA_YMAX  = 475,
   parameter int TIMEOUT_CYC = 1000000
) (
   input logic          clk,
   input logic          Reset_n,
   wwm_turn_sm_if.slave bus
);
   localparam int PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int TW = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [4:0] {
      S_INIT    = 5'b00001,
      S_SHOOT   = 5'b00010,
      S_ANIMATE = 5'b00100,
      S_SCORE   = 5'b01000,
      S_DONE    = 5'b10000
   } state_t;

   state_t                         state;
   logic [PW-1:0]                  cur_player;
   logic [PW-1:0]                  winner;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores_r;
   logic [TW-1:0]                  tmo_cnt;
   logic                           hit_pulse;
   logic                           miss_pulse;

   logic                           hit;
   logic                           out_of_bounds;
   logic                           timed_out;
   logic [SCORE_W-1:0]             cur_score;
   logic [PW-1:0]                  next_player;

   wire [COORD_W-1:0] px = bus.projectileCenterX;
   wire [COORD_W-1:0] py = bus.projectileCenterY;

   assign hit = (px >= bus.tgtXLo) && (px <= bus.tgtXHi) &&
                (py >= bus.tgtYLo) && (py <= bus.tgtYHi);

   // Arena limits are inclusive: touching an edge already counts as out.
   assign out_of_bounds = (px >= COORD_W'(ARENA_XMAX)) || (px <= COORD_W'(ARENA_XMIN)) ||
                          (py >= COORD_W'(ARENA_YMAX)) || (py <= COORD_W'(ARENA_YMIN));

   assign timed_out   = (tmo_cnt == TMO_LAST);
   assign cur_score   = scores_r[int'(cur_player)*SCORE_W +: SCORE_W];
   assign next_player = (cur_player == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player + 1'b1;

   always_ff @(posedge clk) begin
      if (!Reset_n) begin
         state      <= S_INIT;
         cur_player <= '0;
         winner     <= '0;
         scores_r   <= '0;
         tmo_cnt    <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         case (state)
            S_INIT: begin
               if (bus.Start) begin
                  scores_r   <= '0;
                  cur_player <= '0;
                  winner     <= '0;
                  state      <= S_SHOOT;
               end
            end
            S_SHOOT: begin
               if (bus.Fire) begin
                  tmo_cnt <= '0;
                  state   <= S_ANIMATE;
               end
            end
            S_ANIMATE: begin
               // A hit is checked first so a target touching the arena edge still scores.
               if (hit) begin
                  scores_r[int'(cur_player)*SCORE_W +: SCORE_W] <=
                     (cur_score == SCORE_MAX) ? cur_score : cur_score + 1'b1;
                  hit_pulse <= 1'b1;
                  state     <= S_SCORE;
               end else if (out_of_bounds || timed_out) begin
                  miss_pulse <= 1'b1;
                  cur_player <= next_player;
                  state      <= S_SHOOT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_SCORE: begin
               if (cur_score >= SCORE_W'(WIN_SCORE)) begin
                  winner <= cur_player;
                  state  <= S_DONE;
               end else begin
                  cur_player <= next_player;
                  state      <= S_SHOOT;
               end
            end
            S_DONE: begin
               if (bus.Ack) state <= S_INIT;
            end
            default: state <= S_INIT;
         endcase
      end
   end

   assign bus.q_I       = state[0];
   assign bus.q_Shoot   = state[1];
   assign bus.q_Animate = state[2];
   assign bus.q_Score   = state[3];
   assign bus.q_Done    = state[4];
   assign bus.curPlayer = cur_player;
   assign bus.scores    = scores_r;
   assign bus.winner    = winner;
   assign bus.hitPulse  = hit_pulse;
   assign bus.missPulse = miss_pulse;
endmodule

// File: tb/tb_wwm_turn_sm.sv
// Directed bench for wwm_turn_sm: game-rule model checked every cycle plus literal spot checks.
module tb_wwm_turn_sm;
   localparam int NP   = 3;
   localparam int CW   = 10;
   localparam int SW   = 4;
   localparam int WIN  = 2;
   localparam int TMO  = 8;
   localparam int XMIN = 160;
   localparam int XMAX = 775;
   localparam int YMIN = 50;
   localparam int YMAX = 475;
   localparam int SMAX = (1 << SW) - 1;

   localparam int P_IDLE = 0, P_AIM = 1, P_FLY = 2, P_TALLY = 3, P_OVER = 4;

   logic clk;
   logic Reset_n;

   wwm_turn_sm_if #(.NUM_PLAYERS(NP), .COORD_W(CW), .SCORE_W(SW)) bus ();

   wwm_turn_sm #(
      .NUM_PLAYERS(NP), .COORD_W(CW), .SCORE_W(SW), .WIN_SCORE(WIN),
      .ARENA_XMIN(XMIN), .ARENA_XMAX(XMAX), .ARENA_YMIN(YMIN), .ARENA_YMAX(YMAX),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // game-rule model
   int m_phase;
   int m_cur;
   int m_win;
   int m_sc[NP];
   int m_flight;
   bit m_hit;
   bit m_miss;

   function automatic bit in_box();
      int x, y;
      x = int'(bus.projectileCenterX);
      y = int'(bus.projectileCenterY);
      return x >= int'(bus.tgtXLo) && x <= int'(bus.tgtXHi) &&
             y >= int'(bus.tgtYLo) && y <= int'(bus.tgtYHi);
   endfunction

   function automatic bit outside_arena();
      int x, y;
      x = int'(bus.projectileCenterX);
      y = int'(bus.projectileCenterY);
      return x >= XMAX || x <= XMIN || y >= YMAX || y <= YMIN;
   endfunction

   always @(posedge clk) begin
      if (!Reset_n) begin
         m_phase = P_IDLE; m_cur = 0; m_win = 0; m_flight = 0;
         m_hit = 0; m_miss = 0;
         for (int p = 0; p < NP; p++) m_sc[p] = 0;
      end else begin
         m_hit = 0; m_miss = 0;
         case (m_phase)
            P_IDLE: if (bus.Start) begin
               for (int p = 0; p < NP; p++) m_sc[p] = 0;
               m_cur = 0; m_win = 0; m_phase = P_AIM;
            end
            P_AIM: if (bus.Fire) begin
               m_flight = 0; m_phase = P_FLY;
            end
            P_FLY: begin
               m_flight++;
               if (in_box()) begin
                  if (m_sc[m_cur] < SMAX) m_sc[m_cur]++;
                  m_hit = 1; m_phase = P_TALLY;
               end else if (outside_arena() || m_flight == TMO) begin
                  m_miss = 1; m_cur = (m_cur + 1) % NP; m_phase = P_AIM;
               end
            end
            P_TALLY: if (m_sc[m_cur] >= WIN) begin
               m_win = m_cur; m_phase = P_OVER;
            end else begin
               m_cur = (m_cur + 1) % NP; m_phase = P_AIM;
            end
            P_OVER: if (bus.Ack) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
         endcase
      end
   end

   // scoreboard: compare every cycle on the falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [NP*SW-1:0] exp_scores;
         logic [4:0] exp_q, act_q;
         for (int p = 0; p < NP; p++) exp_scores[p*SW +: SW] = SW'(m_sc[p]);
         exp_q = 5'(1 << m_phase);
         act_q = {bus.q_Done, bus.q_Score, bus.q_Animate, bus.q_Shoot, bus.q_I};
         check("state", 32'(act_q), 32'(exp_q));
         check("curPlayer", 32'(bus.curPlayer), 32'(m_cur));
         check("scores", 32'(bus.scores), 32'(exp_scores));
         check("hitPulse", 32'(bus.hitPulse), 32'(m_hit));
         check("missPulse", 32'(bus.missPulse), 32'(m_miss));
         if (m_phase == P_OVER) check("winner", 32'(bus.winner), 32'(m_win));
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_xy(input int x, input int y);
      bus.projectileCenterX = CW'(x);
      bus.projectileCenterY = CW'(y);
   endtask

   task automatic pulse_start();
      bus.Start = 1'b1; tick(1); bus.Start = 1'b0;
   endtask

   task automatic pulse_fire();
      bus.Fire = 1'b1; tick(1); bus.Fire = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.Ack = 1'b1; tick(1); bus.Ack = 1'b0;
   endtask

   int miss_x[3]   = '{780, 160, 400};
   int miss_y[3]   = '{200, 200, 50};
   int miss_cur[3] = '{2, 0, 1};

   initial begin
      Reset_n = 1'b0;
      bus.Start = 1'b0; bus.Ack = 1'b0; bus.Fire = 1'b0;
      bus.tgtXLo = CW'(650); bus.tgtXHi = CW'(675);
      bus.tgtYLo = CW'(470); bus.tgtYHi = CW'(475);
      set_xy(400, 200);
      tick(2);
      cmp_en = 1'b1;
      check("rst q_I", 32'(bus.q_I), 32'd1);
      check("rst scores", 32'(bus.scores), 32'd0);
      Reset_n = 1'b1;
      tick(2);
      check("idle hold", 32'(bus.q_I), 32'd1);

      // first shot hits for player 0
      pulse_start();
      check("start shoot", 32'(bus.q_Shoot), 32'd1);
      set_xy(660, 472);
      pulse_fire();
      check("animate", 32'(bus.q_Animate), 32'd1);
      tick(1);
      check("hit score st", 32'(bus.q_Score), 32'd1);
      check("hit pulse", 32'(bus.hitPulse), 32'd1);
      check("p0 score", 32'(bus.scores), 32'h001);
      tick(1);
      check("hit pulse off", 32'(bus.hitPulse), 32'd0);
      check("next player", 32'(bus.curPlayer), 32'd1);

      // out-of-bounds misses on each arena edge, with wrap 2 -> 0
      for (int i = 0; i < 3; i++) begin
         set_xy(miss_x[i], miss_y[i]);
         pulse_fire();
         tick(1);
         check("miss pulse", 32'(bus.missPulse), 32'd1);
         check("miss cur", 32'(bus.curPlayer), 32'(miss_cur[i]));
         check("miss scores", 32'(bus.scores), 32'h001);
         tick(1);
         check("miss pulse off", 32'(bus.missPulse), 32'd0);
      end

      // hit on the arena edge: hit wins
      set_xy(660, 475);
      pulse_fire();
      tick(1);
      check("edge hit", 32'(bus.hitPulse), 32'd1);
      check("edge no miss", 32'(bus.missPulse), 32'd0);
      check("edge scores", 32'(bus.scores), 32'h011);
      tick(1);
      check("edge cur", 32'(bus.curPlayer), 32'd2);

      // timeout: in bounds, off target
      set_xy(400, 200);
      pulse_fire();
      for (int i = 0; i < TMO - 1; i++) begin
         tick(1);
         check("flying", 32'(bus.q_Animate), 32'd1);
      end
      tick(1);
      check("timeout miss", 32'(bus.missPulse), 32'd1);
      check("timeout cur", 32'(bus.curPlayer), 32'd0);

      // player 0 misses, player 1 hits a second time and wins
      set_xy(780, 200);
      pulse_fire();
      tick(1);
      set_xy(660, 472);
      pulse_fire();
      tick(2);
      check("done", 32'(bus.q_Done), 32'd1);
      check("winner", 32'(bus.winner), 32'd1);
      check("final scores", 32'(bus.scores), 32'h021);
      pulse_fire();
      check("fire ignored", 32'(bus.q_Done), 32'd1);
      pulse_ack();
      check("ack idle", 32'(bus.q_I), 32'd1);
      check("kept scores", 32'(bus.scores), 32'h021);
      check("kept winner", 32'(bus.winner), 32'd1);
      pulse_start();
      check("restart scores", 32'(bus.scores), 32'd0);

      // reset mid-flight with nonzero score
      pulse_fire();
      tick(2);
      check("p0 rescored", 32'(bus.scores), 32'h001);
      set_xy(400, 200);
      pulse_fire();
      tick(2);
      Reset_n = 1'b0;
      tick(1);
      check("rst mid anim", 32'(bus.q_I), 32'd1);
      check("rst mid scores", 32'(bus.scores), 32'd0);
      Reset_n = 1'b1;

      // reset while in the scoring cycle
      pulse_start();
      set_xy(660, 472);
      pulse_fire();
      tick(1);
      check("in score", 32'(bus.q_Score), 32'd1);
      Reset_n = 1'b0;
      tick(1);
      check("rst mid score", 32'(bus.q_I), 32'd1);
      check("rst pulse", 32'(bus.hitPulse), 32'd0);
      Reset_n = 1'b1;
      tick(2);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/wwm_turn_sm.md
WWM_TURN_SM -- requirements
Module: wwm_turn_sm

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_PLAYERS, 2, player count, legal range 2..4
- COORD_W, 10, projectile and target coordinate width
- SCORE_W, 4, per-player score width
- WIN_SCORE, 3, hits needed to win, range 1..2^SCORE_W-1
- ARENA_XMIN / ARENA_XMAX, 160 / 775, horizontal out-of-bounds limits
- ARENA_YMIN / ARENA_YMAX, 50 / 475, vertical out-of-bounds limits
- TIMEOUT_CYC, 1000000, maximum cycles per shot in flight
- Derived: PW = max(1, clog2(NUM_PLAYERS)); TW = clog2(TIMEOUT_CYC).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge
- Reset_n, in, 1, synchronous active-low reset
- Start, in, 1, begin a match
- Ack, in, 1, acknowledge match end
- Fire, in, 1, current player fires
- projectileCenterX / projectileCenterY, in, COORD_W, projectile position
- tgtXLo, tgtXHi, tgtYLo, tgtYHi, in, COORD_W each, inclusive hit box for the current shooter
- q_I, q_Shoot, q_Animate, q_Score, q_Done, out, 1 each, one-hot state
- curPlayer, out, PW, index of the player whose turn it is
- scores, out, NUM_PLAYERS*SCORE_W, player p at bits [p*SCORE_W +: SCORE_W]
- winner, out, PW, winning player index, valid while q_Done
- hitPulse / missPulse, out, 1 each, one-cycle shot-outcome strobes

Function
REQ-003 States SHALL be INIT, SHOOT, ANIMATE, SCORE and DONE, one-hot encoded and driven directly onto the q_* outputs; exactly one q_* SHALL be high in every cycle.
REQ-004 INIT: on Start, the block SHALL clear all scores, set curPlayer=0, and go to SHOOT on the next edge; otherwise it SHALL hold.
REQ-005 SHOOT: on Fire, the block SHALL go to ANIMATE and clear the timeout counter; Fire SHALL be ignored in all other states.
REQ-006 ANIMATE, hit: hit = tgtXLo<=X<=tgtXHi AND tgtYLo<=Y<=tgtYHi (unsigned, inclusive). On a hit the block SHALL go to SCORE, increment scores[curPlayer] (saturating at 2^SCORE_W-1), and assert hitPulse for exactly the next cycle.
REQ-007 ANIMATE, miss: miss = X>=ARENA_XMAX OR X<=ARENA_XMIN OR Y>=ARENA_YMAX OR Y<=ARENA_YMIN, or timeout counter == TIMEOUT_CYC-1. On a miss the block SHALL advance curPlayer, go to SHOOT, and assert missPulse for exactly the next cycle.
REQ-008 Hit SHALL take priority over miss when both conditions hold in the same cycle.
REQ-009 The timeout counter SHALL increment by 1 each ANIMATE cycle that has neither a hit nor a miss; it SHALL be cleared on ANIMATE entry.
REQ-010 SCORE (one cycle): if scores[curPlayer] >= WIN_SCORE, the block SHALL set winner=curPlayer and go to DONE; otherwise it SHALL advance curPlayer and go to SHOOT.
REQ-011 Advancing curPlayer SHALL wrap from NUM_PLAYERS-1 to 0.
REQ-012 DONE: on Ack, the block SHALL go to INIT; scores and winner SHALL be retained until the next Start.
REQ-013 Start, Ack and Fire SHALL be level-sampled; each is meaningful only in its own state (INIT, DONE and SHOOT respectively).
REQ-014 Latency: input condition at edge N SHALL be reflected in state and outputs after edge N; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-015 When Reset_n=0 at a clk edge, the block SHALL set state=INIT, curPlayer=0, all scores=0, winner=0, hitPulse=missPulse=0, and timeout counter=0.
REQ-016 Reset SHALL override every other input in every state, including mid-ANIMATE and mid-SCORE.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset, Start, Fire, then X=660/Y=472 inside box 650..675 x 470..475 -> hitPulse 1 cycle, scores[0]=1, SCORE, then SHOOT with curPlayer=1.
- In ANIMATE, X=780 -> missPulse 1 cycle, scores unchanged, curPlayer 0->1; with NUM_PLAYERS=3, curPlayer 2 wraps to 0.
- Point inside the hit box and also at Y=475=ARENA_YMAX -> hit wins, no missPulse.
- TIMEOUT_CYC=8, projectile held in-bounds and off-target -> missPulse exactly 8 cycles after ANIMATE entry.
- WIN_SCORE=2, player 1 hits twice -> DONE, winner=1, scores retained; Ack -> INIT; Start -> scores=0.
- Reset_n=0 mid-ANIMATE with scores nonzero -> next cycle q_I=1 and all scores=0.
